// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch front end driving Avalon-MM reads into the IF/ID register
//   clk, reset           : clock, synchronous active-high reset
//   pc_in, pc_write      : fetch address from / write-enable back to the PC register
//   stall_in             : decode hazard stall, freezes IF/ID
//   instr_address/read   : Avalon read address and strobe
//   instr_waitrequest    : memory not ready, read held
//   instr_readdata       : returned instruction word
//   if_id_*              : IF/ID instruction, its address and valid flag
//   active               : low once the halt address (PC = 0) is reached
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] NOP_WORD     = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        stall_in,
    output logic        pc_write,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        active
);
    typedef enum logic [1:0] {FETCH = 2'd0, HELD = 2'd1, HALTED = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [31:0] hold_buf_q, hold_pc_q, instr_q, pc_q;
    logic        valid_q, fetch_done;

    always_ff @(posedge clk)
        state_q <= reset ? FETCH : state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   state_d = pc_in == 32'd0 ? HALTED : (fetch_done && stall_in) ? HELD : FETCH;
            HELD:    state_d = stall_in ? HELD : FETCH;
            HALTED:  state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    // Read strobe drops during reset so an outstanding transfer is abandoned.
    // pc_write marks exactly the cycles that load a valid word into IF/ID.
    always_comb begin
        instr_read    = !reset && state_q == FETCH && pc_in != 32'd0;
        instr_address = pc_in;
        fetch_done    = instr_read && !instr_waitrequest;
        pc_write      = !reset && !stall_in && (fetch_done || state_q == HELD);
        active        = state_q != HALTED;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= NOP_WORD;
            pc_q       <= RESET_VECTOR;
            valid_q    <= 1'b0;
            hold_buf_q <= 32'd0;
            hold_pc_q  <= 32'd0;
        end else begin
            if (pc_write) begin
                instr_q <= state_q == HELD ? hold_buf_q : instr_readdata;
                pc_q    <= state_q == HELD ? hold_pc_q : pc_in;
                valid_q <= 1'b1;
            end else if (!stall_in) begin
                instr_q <= NOP_WORD;
                valid_q <= 1'b0;
            end
            // A word returning under stall is parked instead of being re-fetched.
            if (fetch_done && stall_in) begin
                hold_buf_q <= instr_readdata;
                hold_pc_q  <= pc_in;
            end
        end
    end

    assign if_id_instruction = instr_q;
    assign if_id_pc          = pc_q;
    assign if_id_valid       = valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
    logic        clk = 1'b0, reset = 1'b1, stall_in = 1'b0, instr_waitrequest = 1'b0;
    logic [31:0] pc_in = 32'hBFC00000, instr_readdata = 32'd0;
    logic        pc_write, instr_read, if_id_valid, active;
    logic [31:0] instr_address, if_id_instruction, if_id_pc;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .stall_in(stall_in), .pc_write(pc_write),
        .instr_address(instr_address), .instr_read(instr_read),
        .instr_waitrequest(instr_waitrequest), .instr_readdata(instr_readdata),
        .if_id_instruction(if_id_instruction), .if_id_pc(if_id_pc),
        .if_id_valid(if_id_valid), .active(active)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        v;
        logic        act;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0, n_fail = 0;
    int          m_st = 0;
    logic [31:0] m_hb = 0, m_hp = 0, m_ins = 0, m_pc = 32'hBFC00000;
    logic        m_v = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a == 32'hBFC00004 ? 32'h24020005 : {a[15:0] ^ 16'h1234, a[31:16]};
    endfunction

    task automatic cyc(input logic r, input logic st, input logic wr);
        logic rd, done, pw;
        exp_t e, o;
        @(negedge clk);
        reset = r; stall_in = st; instr_waitrequest = wr;
        instr_readdata = wr ? 32'hDEADBEEF : mem(pc_in);
        #1;
        rd   = !r && m_st == 0 && pc_in != 0;
        done = rd && !wr;
        pw   = !r && !st && (done || m_st == 1);
        chk("instr_read", {31'd0, instr_read}, {31'd0, rd});
        chk("instr_address", instr_address, pc_in);
        chk("pc_write", {31'd0, pc_write}, {31'd0, pw});
        if (r) begin
            m_st = 0; m_ins = 0; m_pc = 32'hBFC00000; m_v = 0; m_hb = 0; m_hp = 0;
        end else begin
            if (pw) begin
                m_ins = m_st == 1 ? m_hb : instr_readdata;
                m_pc  = m_st == 1 ? m_hp : pc_in;
                m_v   = 1;
            end else if (!st) begin
                m_ins = 0; m_v = 0;
            end
            if (done && st) begin m_hb = instr_readdata; m_hp = pc_in; end
            if (m_st == 0) m_st = pc_in == 0 ? 2 : (done && st) ? 1 : 0;
            else if (m_st == 1 && !st) m_st = 0;
        end
        e = '{m_ins, m_pc, m_v, m_st != 2};
        sb.push_back(e);
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk("if_id_instruction", if_id_instruction, o.ins);
        chk("if_id_pc", if_id_pc, o.pc);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, o.v});
        chk("active", {31'd0, active}, {31'd0, o.act});
        if (pw) pc_in = pc_in + 32'd4;
    endtask

    initial begin
        cyc(1, 0, 0); cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0);
        chk("pc_after_3", pc_in, 32'hBFC0000C);
        cyc(1, 0, 0); pc_in = 32'hBFC00000;
        cyc(0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);
        chk("wait_word", if_id_instruction, 32'h24020005);
        cyc(1, 0, 0); pc_in = 32'hBFC00000;
        cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(0, 1, 0);
        cyc(0, 0, 0);
        chk("held_release_pc", if_id_pc, 32'hBFC00004);
        cyc(0, 0, 0);
        cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 0, 0);
        cyc(0, 1, 0); cyc(1, 1, 0);
        cyc(0, 0, 0); cyc(0, 0, 1); cyc(1, 0, 1);
        cyc(0, 0, 0);
        pc_in = 32'd0;
        cyc(0, 0, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
        pc_in = 32'hBFC00010;
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0); cyc(0, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
